// File: rtl/interrupt_sequencer.sv
// Interrupt-entry sequencer: waits for a safe point, drains the pipeline, pushes
// the resume PC and flags, reads the 32-bit handler vector and redirects fetch.
module interrupt_sequencer #(
   parameter int unsigned PC_W         = 32,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned FLAG_W       = 3,
   parameter int unsigned VECTOR_ADDR  = 0,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_int_req,
   input  logic              i_pipeline_busy,
   input  logic              i_decode_imm,
   input  logic              i_branch_taken,
   input  logic [PC_W-1:0]   i_resume_pc,
   input  logic [FLAG_W-1:0] i_flags,
   input  logic              i_mem_grant,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_stall_fetch,
   output logic              o_flush_f_d,
   output logic              o_mem_req,
   output logic              o_mem_push,
   output logic [DATA_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_pc_load,
   output logic [PC_W-1:0]   o_pc_value,
   output logic              o_int_ack,
   output logic              o_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_PUSH_HI,
      S_PUSH_LO,
      S_PUSH_FL,
      S_VEC_HI,
      S_VEC_LO,
      S_JUMP
   } state_t;

   localparam logic [2:0]        DRAIN_LAST  = 3'(DRAIN_CYCLES - 1);
   localparam logic [DATA_W-1:0] VEC_ADDR_HI = DATA_W'(VECTOR_ADDR);
   localparam logic [DATA_W-1:0] VEC_ADDR_LO = DATA_W'(VECTOR_ADDR + 1);

   state_t              state_q, state_d;
   logic                req_prev_q, req_prev_d;
   logic                pending_q, pending_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;
   logic [DATA_W-1:0]   vec_hi_q, vec_hi_d;
   logic [DATA_W-1:0]   vec_lo_q, vec_lo_d;
   logic                leave_idle;

   always_comb begin
      state_d    = state_q;
      req_prev_d = i_int_req;
      cnt_d      = cnt_q;
      pc_d       = pc_q;
      flags_d    = flags_q;
      vec_hi_d   = vec_hi_q;
      vec_lo_d   = vec_lo_q;
      leave_idle = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pending_q && !i_pipeline_busy && !i_decode_imm && !i_branch_taken) begin
               state_d    = S_DRAIN;
               cnt_d      = '0;
               leave_idle = 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               pc_d    = i_resume_pc;
               flags_d = i_flags;
               cnt_d   = '0;
               state_d = S_PUSH_HI;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_PUSH_HI: if (i_mem_grant) state_d = S_PUSH_LO;
         S_PUSH_LO: if (i_mem_grant) state_d = S_PUSH_FL;
         S_PUSH_FL: if (i_mem_grant) state_d = S_VEC_HI;
         S_VEC_HI: begin
            if (i_mem_grant) begin
               vec_hi_d = i_mem_rdata;
               state_d  = S_VEC_LO;
            end
         end
         S_VEC_LO: begin
            if (i_mem_grant) begin
               vec_lo_d = i_mem_rdata;
               state_d  = S_JUMP;
            end
         end
         S_JUMP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // a new edge in the same cycle as the clear keeps the request pending
      pending_d = (i_int_req & ~req_prev_q) | (pending_q & ~leave_idle);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         req_prev_q <= 1'b0;
         pending_q  <= 1'b0;
         cnt_q      <= '0;
         pc_q       <= '0;
         flags_q    <= '0;
         vec_hi_q   <= '0;
         vec_lo_q   <= '0;
      end else begin
         state_q    <= state_d;
         req_prev_q <= req_prev_d;
         pending_q  <= pending_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         flags_q    <= flags_d;
         vec_hi_q   <= vec_hi_d;
         vec_lo_q   <= vec_lo_d;
      end
   end

   always_comb begin
      o_stall_fetch = (state_q != S_IDLE) && (state_q != S_JUMP);
      o_flush_f_d   = (state_q == S_DRAIN) || (state_q == S_JUMP);
      o_mem_req     = 1'b0;
      o_mem_push    = 1'b0;
      o_mem_addr    = '0;
      o_mem_wdata   = '0;
      o_pc_load     = 1'b0;
      o_pc_value    = '0;
      o_int_ack     = 1'b0;
      o_busy        = (state_q != S_IDLE);
      case (state_q)
         S_PUSH_HI: begin
            o_mem_req   = 1'b1;
            o_mem_push  = 1'b1;
            o_mem_wdata = pc_q[PC_W-1:DATA_W];
         end
         S_PUSH_LO: begin
            o_mem_req   = 1'b1;
            o_mem_push  = 1'b1;
            o_mem_wdata = pc_q[DATA_W-1:0];
         end
         S_PUSH_FL: begin
            o_mem_req   = 1'b1;
            o_mem_push  = 1'b1;
            o_mem_wdata = {{(DATA_W-FLAG_W){1'b0}}, flags_q};
         end
         S_VEC_HI: begin
            o_mem_req  = 1'b1;
            o_mem_addr = VEC_ADDR_HI;
         end
         S_VEC_LO: begin
            o_mem_req  = 1'b1;
            o_mem_addr = VEC_ADDR_LO;
         end
         S_JUMP: begin
            o_pc_load  = 1'b1;
            o_pc_value = {vec_hi_q, vec_lo_q};
            o_int_ack  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Multi-cycle controller that turns an external interrupt request into the hardware interrupt-entry sequence for the 5-stage pipeline. It latches the request and waits for a safe point: no call/ret in progress, no immediate word in decode, no taken branch. It then drains the pipeline, pushes the resume PC and the flags through the memory-stage port, fetches the 32-bit handler address from the vector words, and redirects fetch. It sits beside hazard_unit; its stall/flush outputs are ORed into the pipeline control.

Parameters:
PC_W, 32, program counter width (must equal 2*DATA_W)
DATA_W, 16, memory word width
FLAG_W, 3, CCR width (Z,N,C), pushed zero-extended to DATA_W
VECTOR_ADDR, 0, word address of vector high half; low half at VECTOR_ADDR+1
DRAIN_CYCLES, 2, fetch-stalled cycles before state save (range 1..7)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-high reset
i_int_req  in  1  external interrupt, already synchronised; rising edge = one request
i_pipeline_busy  in  1  hazard_unit call/ret state active
i_decode_imm  in  1  decode holds first word of 32-bit instruction
i_branch_taken  in  1  branch resolved taken this cycle
i_resume_pc  in  PC_W  address of next instruction to execute (sampled at drain end)
i_flags  in  FLAG_W  current CCR
i_mem_grant  in  1  memory-stage port accepts current request this cycle
i_mem_rdata  in  DATA_W  read data, valid in the grant cycle
o_stall_fetch  out  1  freeze PC and F/D register
o_flush_f_d  out  1  insert NOP into F/D
o_mem_req  out  1  memory request valid
o_mem_push  out  1  request is a stack push (SP decremented by memory stage)
o_mem_addr  out  DATA_W  read address (vector reads only, else 0)
o_mem_wdata  out  DATA_W  push data
o_pc_load  out  1  load o_pc_value into PC (one cycle)
o_pc_value  out  PC_W  handler address
o_int_ack  out  1  one-cycle pulse, entry complete
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, pending=0, drain counter=0, captured PC/flags/vector=0. All outputs 0.
- Edge detect: pending set on i_int_req 0->1 (registered previous value). Cleared on leaving IDLE. Edge during a sequence sets pending again (one deep; extra edges lost). Set and clear in the same cycle: set wins.
- IDLE: go to DRAIN when pending & !i_pipeline_busy & !i_decode_imm & !i_branch_taken. Otherwise hold.
- DRAIN: o_stall_fetch=1, o_flush_f_d=1. Counter counts DRAIN_CYCLES cycles. On the last cycle, capture i_resume_pc and i_flags, then go to PUSH_HI.
- PUSH_HI / PUSH_LO / PUSH_FL: o_mem_req=1, o_mem_push=1. o_mem_wdata = pc[31:16], pc[15:0], then zero-extended flags. Advance only on a clock edge with i_mem_grant=1; else hold with outputs stable.
- VEC_HI / VEC_LO: o_mem_req=1, o_mem_push=0, o_mem_addr=VECTOR_ADDR / VECTOR_ADDR+1. Capture i_mem_rdata into vector hi/lo on grant, then advance.
- JUMP: o_pc_load=1, o_pc_value={vec_hi,vec_lo}, o_int_ack=1, o_flush_f_d=1. Next state IDLE.
- o_stall_fetch=1 in every state except IDLE and JUMP.
- Latency with grant held high: request edge to o_pc_load = 1 (IDLE) + DRAIN_CYCLES + 5 + 1 = 9 cycles at default.
- Outputs are combinational from state and registers only; no path from i_int_req to any output.
- Reset asserted mid-sequence: immediate return to IDLE and all outputs 0. The partially pushed stack is not repaired.
- i_branch_taken or i_pipeline_busy after IDLE is ignored; the drain covers them.

Test Plan:
- Single request, grant tied 1, resume_pc=0x0000_1234, flags=3'b101, mem[0]=0x0000, mem[1]=0x0400 -> pushes 0x0000, 0x1234, 0x0005; o_pc_load with 0x0000_0400 and o_int_ack exactly 9 cycles after the edge; o_busy falls the next cycle.
- Request while i_pipeline_busy=1 for 3 cycles, or i_decode_imm=1 -> stays IDLE, no stall, until both are low; then normal entry.
- Grant low for 4 cycles during PUSH_LO -> o_mem_wdata stays 0x1234 and the state holds; entry completes 4 cycles late.
- Second i_int_req edge during VEC_HI -> after the first ack, returns to IDLE and starts a second full sequence. Third edge during the same window is lost.
- i_reset pulsed during PUSH_FL -> all outputs 0 asynchronously, o_busy=0, pending cleared; a later request runs a full sequence.
- i_int_req held high for 20 cycles -> exactly one sequence, one o_int_ack.
